// File: rtl/pipe_hazard_pkg.sv
// Shared constants and helpers for the pipeline data-hazard unit.
// Default widths, latencies, counter width and slot-latency lookup.
package pipe_hazard_pkg;

    localparam int DATA_W_D   = 32;
    localparam int REG_AW_D   = 5;
    localparam int NSTAGE_D   = 3;
    localparam int ALU_LAT_D  = 1;
    localparam int LOAD_LAT_D = 2;
    localparam int CNT_W      = 16;

    // sel encoding: 0 selects the register file, i selects slot i
    localparam int SEL_RF = 0;

    function automatic int sel_w(input int nstage);
        return $clog2(nstage + 1);
    endfunction

    // first slot index at which a write's result exists
    function automatic int slot_lat(
        input logic is_load,
        input int   alu_lat,
        input int   load_lat
    );
        return is_load ? load_lat : alu_lat;
    endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Priority search of one ID source operand over the in-flight slots.
// Ports: use_i/ra_i operand, vld_i/wn_i/ld_i slot state; hit_o/ready_o/idx_o.
module pipe_fwd_match
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_D,
    parameter int NSTAGE   = NSTAGE_D,
    parameter int ALU_LAT  = ALU_LAT_D,
    parameter int LOAD_LAT = LOAD_LAT_D,
    parameter int SEL_W    = sel_w(NSTAGE)
) (
    input  logic                     use_i,
    input  logic [REG_AW-1:0]        ra_i,
    input  logic [NSTAGE-1:0]        vld_i,
    input  logic [NSTAGE*REG_AW-1:0] wn_i,
    input  logic [NSTAGE-1:0]        ld_i,
    output logic                     hit_o,
    output logic                     ready_o,
    output logic [SEL_W-1:0]         idx_o
);

    // Walk oldest to youngest so the youngest match is the last write.
    always_comb begin
        hit_o   = 1'b0;
        ready_o = 1'b0;
        idx_o   = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (use_i && (ra_i != '0) && vld_i[i]
                && (wn_i[i*REG_AW +: REG_AW] == ra_i)) begin
                hit_o   = 1'b1;
                idx_o   = SEL_W'(i + 1);
                ready_o = (i + 1) >=
                          slot_lat(ld_i[i], ALU_LAT, LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based forwarding and load-use stall unit beside ID.
// Ports: ID operand/dest info, flush, slot results, rf reads; stall, operands, sels, stall_cnt.
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int DATA_W   = DATA_W_D,
    parameter int REG_AW   = REG_AW_D,
    parameter int NSTAGE   = NSTAGE_D,
    parameter int ALU_LAT  = ALU_LAT_D,
    parameter int LOAD_LAT = LOAD_LAT_D
) (
    input  logic                         clk,
    input  logic                         clrn,
    input  logic                         id_valid,
    input  logic [REG_AW-1:0]            id_rs,
    input  logic [REG_AW-1:0]            id_rt,
    input  logic                         id_use_rs,
    input  logic                         id_use_rt,
    input  logic                         id_wreg,
    input  logic                         id_m2reg,
    input  logic [REG_AW-1:0]            id_wn,
    input  logic                         flush,
    input  logic [NSTAGE*DATA_W-1:0]     stage_data,
    input  logic [DATA_W-1:0]            rf_qa,
    input  logic [DATA_W-1:0]            rf_qb,
    output logic                         stall,
    output logic [DATA_W-1:0]            opa,
    output logic [DATA_W-1:0]            opb,
    output logic [$clog2(NSTAGE+1)-1:0]  sel_a,
    output logic [$clog2(NSTAGE+1)-1:0]  sel_b,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int SEL_W = $clog2(NSTAGE + 1);

    logic [NSTAGE-1:0]        vld_q, vld_d;
    logic [NSTAGE-1:0]        ld_q, ld_d;
    logic [NSTAGE*REG_AW-1:0] wn_q, wn_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic             hit_a, rdy_a, hit_b, rdy_b;
    logic [SEL_W-1:0] idx_a, idx_b;
    logic             fwd_a, fwd_b, raw_a, raw_b;
    logic             ins;

    pipe_fwd_match #(
        .REG_AW   (REG_AW),
        .NSTAGE   (NSTAGE),
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT),
        .SEL_W    (SEL_W)
    ) u_match_a (
        .use_i   (id_use_rs),
        .ra_i    (id_rs),
        .vld_i   (vld_q),
        .wn_i    (wn_q),
        .ld_i    (ld_q),
        .hit_o   (hit_a),
        .ready_o (rdy_a),
        .idx_o   (idx_a)
    );

    pipe_fwd_match #(
        .REG_AW   (REG_AW),
        .NSTAGE   (NSTAGE),
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT),
        .SEL_W    (SEL_W)
    ) u_match_b (
        .use_i   (id_use_rt),
        .ra_i    (id_rt),
        .vld_i   (vld_q),
        .wn_i    (wn_q),
        .ld_i    (ld_q),
        .hit_o   (hit_b),
        .ready_o (rdy_b),
        .idx_o   (idx_b)
    );

    assign fwd_a = hit_a & rdy_a;
    assign fwd_b = hit_b & rdy_b;
    assign raw_a = hit_a & ~rdy_a;
    assign raw_b = hit_b & ~rdy_b;

    // flush kills the ID instruction, so it can neither stall nor record
    assign stall = id_valid & ~flush & (raw_a | raw_b);

    assign ins = id_valid & ~flush & ~stall & id_wreg
               & (id_wn != '0);

    always_comb begin
        vld_d = '0;
        ld_d  = '0;
        wn_d  = '0;
        vld_d[0] = ins;
        ld_d[0]  = ins & id_m2reg;
        wn_d[REG_AW-1:0] = ins ? id_wn : '0;
        for (int i = 1; i < NSTAGE; i++) begin
            vld_d[i] = vld_q[i-1];
            ld_d[i]  = ld_q[i-1];
            wn_d[i*REG_AW +: REG_AW] =
                wn_q[(i-1)*REG_AW +: REG_AW];
        end
    end

    always_comb begin
        opa   = rf_qa;
        opb   = rf_qb;
        sel_a = SEL_W'(SEL_RF);
        sel_b = SEL_W'(SEL_RF);
        for (int i = 0; i < NSTAGE; i++) begin
            if (fwd_a && (idx_a == SEL_W'(i + 1))) begin
                opa   = stage_data[i*DATA_W +: DATA_W];
                sel_a = idx_a;
            end
            if (fwd_b && (idx_b == SEL_W'(i + 1))) begin
                opb   = stage_data[i*DATA_W +: DATA_W];
                sel_b = idx_b;
            end
        end
    end

    assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vld_q <= '0;
            ld_q  <= '0;
            wn_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            ld_q  <= ld_d;
            wn_q  <= wn_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with an expectation queue.
// A second instance with never-ready loads drives the counter to saturation.
module tb_pipe_hazard_unit;
    import pipe_hazard_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn, id_valid, id_use_rs, id_use_rt;
    logic        id_wreg, id_m2reg, flush;
    logic [4:0]  id_rs, id_rt, id_wn;
    logic [95:0] stage_data;
    logic [31:0] rf_qa, rf_qb, opa, opb;
    logic        stall;
    logic [1:0]  sel_a, sel_b;
    logic [15:0] stall_cnt;

    pipe_hazard_unit dut (
        .clk(clk), .clrn(clrn), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wn(id_wn),
        .flush(flush), .stage_data(stage_data),
        .rf_qa(rf_qa), .rf_qb(rf_qb), .stall(stall),
        .opa(opa), .opb(opb), .sel_a(sel_a), .sel_b(sel_b),
        .stall_cnt(stall_cnt)
    );

    logic          clrn2;
    logic          stall2;
    logic [31:0]   opa2, opb2;
    logic [3:0]    sel_a2, sel_b2;
    logic [15:0]   cnt2;
    logic [479:0]  sd2;

    // Loads never become ready here: a load/consumer in ID stalls 15 of 16 cycles.
    pipe_hazard_unit #(
        .NSTAGE(15), .LOAD_LAT(16)
    ) u_sat (
        .clk(clk), .clrn(clrn2), .id_valid(1'b1),
        .id_rs(5'd0), .id_rt(5'd4),
        .id_use_rs(1'b0), .id_use_rt(1'b1),
        .id_wreg(1'b1), .id_m2reg(1'b1), .id_wn(5'd4),
        .flush(1'b0), .stage_data(sd2),
        .rf_qa(32'h0), .rf_qb(32'h0), .stall(stall2),
        .opa(opa2), .opb(opb2), .sel_a(sel_a2), .sel_b(sel_b2),
        .stall_cnt(cnt2)
    );

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic exp_v(input string tag, input logic [31:0] v);
        q.push_back('{tag, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_run++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL queue_empty: observed %h required none", obs);
            return;
        end
        e = q.pop_front();
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   e.tag, obs, e.v);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(
        input logic       v,
        input logic [4:0] rs, input logic urs,
        input logic [4:0] rt, input logic urt,
        input logic       wr, input logic ld,
        input logic [4:0] wn
    );
        id_valid  = v;
        id_rs     = rs;
        id_use_rs = urs;
        id_rt     = rt;
        id_use_rt = urt;
        id_wreg   = wr;
        id_m2reg  = ld;
        id_wn     = wn;
    endtask

    int nst;
    int cyc;

    initial begin
        clrn  = 1'b0;
        clrn2 = 1'b0;
        flush = 1'b0;
        sd2   = '0;
        stage_data = '0;
        rf_qa = 32'hAAAA_0001;
        rf_qb = 32'hBBBB_0002;
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        #7;
        exp_v("rst_stall", 32'd0);      chk(32'(stall));
        exp_v("rst_sel_a", 32'd0);      chk(32'(sel_a));
        exp_v("rst_opa", 32'hAAAA_0001); chk(opa);
        exp_v("rst_cnt", 32'd0);        chk(32'(stall_cnt));
        clrn = 1'b1;

        // empty scoreboard
        id_set(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        exp_v("t1_stall", 32'd0);        chk(32'(stall));
        exp_v("t1_sel_a", 32'd0);        chk(32'(sel_a));
        exp_v("t1_sel_b", 32'd0);        chk(32'(sel_b));
        exp_v("t1_opa", 32'hAAAA_0001);  chk(opa);
        exp_v("t1_opb", 32'hBBBB_0002);  chk(opb);

        // ALU result forwarded from EX
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3);
        nxt();
        id_set(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        stage_data[31:0] = 32'h11;
        #1;
        exp_v("t2_sel_a", 32'd1);   chk(32'(sel_a));
        exp_v("t2_opa", 32'h11);    chk(opa);
        exp_v("t2_stall", 32'd0);   chk(32'(stall));

        // load-use: consumer also writes $9 and reads it back
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4);
        nxt();
        id_set(1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd9);
        stage_data[63:32] = 32'h44;
        #1;
        exp_v("t3_stall", 32'd1);   chk(32'(stall));
        exp_v("t3_cnt0", 32'd0);    chk(32'(stall_cnt));
        nxt();
        exp_v("t3_stall_end", 32'd0); chk(32'(stall));
        exp_v("t3_sel_b", 32'd2);     chk(32'(sel_b));
        exp_v("t3_opb", 32'h44);      chk(opb);
        exp_v("t3_bubble", 32'd0);    chk(32'(sel_a));
        exp_v("t3_cnt1", 32'd1);      chk(32'(stall_cnt));

        // youngest of two writers wins
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7);
        nxt();
        nxt();
        id_set(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        stage_data[31:0]  = 32'hA;
        stage_data[63:32] = 32'hB;
        #1;
        exp_v("t4_opa", 32'hA);    chk(opa);
        exp_v("t4_sel_a", 32'd1);  chk(32'(sel_a));

        // flush beats a load-use hazard
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd6);
        nxt();
        id_set(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd8);
        flush = 1'b1;
        #1;
        exp_v("t5_flush_stall", 32'd0); chk(32'(stall));
        nxt();
        flush = 1'b0;
        id_set(1'b1, 5'd8, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0);
        stage_data[63:32] = 32'h66;
        #1;
        exp_v("t5_slot1_empty", 32'd0);   chk(32'(sel_a));
        exp_v("t5_opa", 32'hAAAA_0001);   chk(opa);
        exp_v("t5_ld_sel_b", 32'd2);      chk(32'(sel_b));
        exp_v("t5_ld_opb", 32'h66);       chk(opb);

        // writes to $0 are not tracked
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0);
        nxt();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        exp_v("t5_r0_sel_a", 32'd0);   chk(32'(sel_a));
        exp_v("t5_r0_sel_b", 32'd0);   chk(32'(sel_b));
        exp_v("t5_cnt", 32'd1);        chk(32'(stall_cnt));

        // reset in the middle of a stall
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4);
        nxt();
        id_set(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        exp_v("t6_pre_stall", 32'd1);  chk(32'(stall));
        clrn = 1'b0;
        #1;
        exp_v("t6_rst_stall", 32'd0);  chk(32'(stall));
        exp_v("t6_rst_cnt", 32'd0);    chk(32'(stall_cnt));
        clrn = 1'b1;
        nxt();
        exp_v("t6_empty_stall", 32'd0); chk(32'(stall));
        exp_v("t6_empty_sel_b", 32'd0); chk(32'(sel_b));

        // drive the saturating counter past 16'hFFFF
        @(negedge clk);
        clrn2 = 1'b1;
        nst = 0;
        cyc = 0;
        while (nst < 70000 && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            if (stall2) begin
                nst++;
                if (nst == 100) begin
                    exp_v("t6_cnt_100", 32'd99);
                    chk(32'(cnt2));
                end
            end
        end
        exp_v("t6_stall_budget", 32'd70000); chk(32'(nst));
        exp_v("t6_cnt_sat", 32'h0000_FFFF);  chk(32'(cnt2));
        nxt();
        exp_v("t6_cnt_hold", 32'h0000_FFFF); chk(32'(cnt2));

        cyc = 0;
        while (!stall2 && cyc < 20) begin
            nxt();
            cyc++;
        end
        exp_v("t6_sat_stall", 32'd1);  chk(32'(stall2));
        clrn2 = 1'b0;
        #1;
        exp_v("t6_sat_rst_stall", 32'd0); chk(32'(stall2));
        exp_v("t6_sat_rst_cnt", 32'd0);   chk(32'(cnt2));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
